// File: rtl/common.sv
// Shared execute-side definitions: M-extension op codes, decode helpers and iteration counts.
package common;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned MULDIV_N64 = 64;
  localparam int unsigned MULDIV_N32 = 32;

  typedef enum logic [3:0] {
    MUL   = 4'd0,
    MULW  = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    REM   = 4'd4,
    REMU  = 4'd5,
    DIVW  = 4'd6,
    DIVUW = 4'd7,
    REMW  = 4'd8,
    REMUW = 4'd9
  } muldiv_op_t;

  typedef struct packed {
    logic is_mul;
    logic is_rem;
    logic is_w;
    logic is_signed;
  } muldiv_dec_t;

  // Per-operation context latched at accept and used for the final fix-up.
  typedef struct packed {
    logic is_mul;
    logic is_rem;
    logic is_w;
    logic q_neg;
    logic r_neg;
  } muldiv_ctx_t;

  function automatic muldiv_dec_t muldiv_decode(input muldiv_op_t op);
    muldiv_dec_t d;
    d.is_mul    = (op == MUL) || (op == MULW);
    d.is_rem    = op inside {REM, REMU, REMW, REMUW};
    d.is_w      = op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    d.is_signed = op inside {DIV, REM, DIVW, REMW};
    return d;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/pipes.sv
// Pipeline-side state types shared by multi-cycle execute units.
package pipes;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Decode-to-muldiv request/response bundle; master is the pipeline, slave is the unit.
interface muldiv_unit_if;
  import common::*;

  logic            start;
  muldiv_op_t      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            busy;
  logic            finish;
  logic [XLEN-1:0] result_s;
  logic [XLEN-1:0] result_d;

  modport master (output start, op, src1, src2, flush,
                  input  busy, finish, result_s, result_d);
  modport slave  (input  start, op, src1, src2, flush,
                  output busy, finish, result_s, result_d);
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Restoring-divide datapath: partial remainder and quotient shift registers with one-step subtract.
module div_core
  import common::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_c_o,
  output logic [XLEN-1:0] rem_nxt_c_o
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN:0]   shifted_c;
  logic [XLEN:0]   diff_c;

  // One quotient bit: the extra top bit of diff_c is the borrow of the trial subtract.
  always_comb begin
    shifted_c   = {rem_q, quo_q[XLEN-1]};
    diff_c      = shifted_c - {1'b0, dvsr_q};
    quo_nxt_c_o = {quo_q[XLEN-2:0], ~diff_c[XLEN]};
    rem_nxt_c_o = diff_c[XLEN] ? shifted_c[XLEN-1:0] : diff_c[XLEN-1:0];
  end

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    if (load_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      quo_d  = quo_nxt_c_o;
      rem_d  = rem_nxt_c_o;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: IDLE/BUSY/DONE FSM, shift-add multiply, sign fix-up.
// Define MULDIV_FAST_MUL_EN to resolve MUL/MULW in a single BUSY cycle with a combinational multiplier.
module muldiv_unit
  import common::*;
  import pipes::*;
(
  input  logic         clk,
  input  logic         resetn,
  muldiv_unit_if.slave bus
);

  localparam int unsigned     CNT_W = 7;
  localparam logic [XLEN-1:0] MIN64 = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN32 = {{(XLEN-31){1'b1}}, 31'd0};

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_ctx_t      ctx_q, ctx_d;
  logic [XLEN-1:0]  mcand_q, mplier_q;
  logic             busy_q, finish_q;
  logic [XLEN-1:0]  res_s_q, res_s_d, res_d_q, res_d_d;
  logic             mul_load_c, mul_step_c, div_load_c, div_step_c;
  muldiv_dec_t      in_dec_c;
  logic [XLEN-1:0]  opa_c, opb_c, abs_a_c, abs_b_c, dividend_c;
  logic [XLEN-1:0]  special_c, raw_c, final_c, mul_c;
  logic [XLEN-1:0]  quo_nxt_c, rem_nxt_c;
  logic             div0_c, ovf_c;

  // Operand extension, magnitudes and the early-out divide cases, all from the request.
  always_comb begin
    in_dec_c = muldiv_decode(bus.op);
    if (in_dec_c.is_w) begin
      opa_c = in_dec_c.is_signed ? sext32(bus.src1[31:0]) : {32'd0, bus.src1[31:0]};
      opb_c = in_dec_c.is_signed ? sext32(bus.src2[31:0]) : {32'd0, bus.src2[31:0]};
    end else begin
      opa_c = bus.src1;
      opb_c = bus.src2;
    end
    abs_a_c    = (in_dec_c.is_signed && opa_c[XLEN-1]) ? -opa_c : opa_c;
    abs_b_c    = (in_dec_c.is_signed && opb_c[XLEN-1]) ? -opb_c : opb_c;
    dividend_c = in_dec_c.is_w ? {abs_a_c[31:0], 32'd0} : abs_a_c;
    div0_c     = !in_dec_c.is_mul && (opb_c == '0);
    ovf_c      = !in_dec_c.is_mul && in_dec_c.is_signed && (opb_c == '1) &&
                 (opa_c == (in_dec_c.is_w ? MIN32 : MIN64));
    if (div0_c) begin
      special_c = in_dec_c.is_rem ? (in_dec_c.is_w ? sext32(bus.src1[31:0]) : bus.src1) : '1;
    end else begin
      special_c = in_dec_c.is_rem ? '0 : opa_c;
    end
  end

  // Result fix-up on the value produced by the final step.
  always_comb begin
    if (ctx_q.is_mul) begin
      raw_c = mul_c;
    end else if (ctx_q.is_rem) begin
      raw_c = ctx_q.r_neg ? -rem_nxt_c : rem_nxt_c;
    end else begin
      raw_c = ctx_q.q_neg ? -quo_nxt_c : quo_nxt_c;
    end
    final_c = ctx_q.is_w ? sext32(raw_c[31:0]) : raw_c;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctx_d      = ctx_q;
    res_s_d    = '0;
    res_d_d    = res_d_q;
    mul_load_c = 1'b0;
    mul_step_c = 1'b0;
    div_load_c = 1'b0;
    div_step_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ctx_d.is_mul = in_dec_c.is_mul;
          ctx_d.is_rem = in_dec_c.is_rem;
          ctx_d.is_w   = in_dec_c.is_w;
          ctx_d.q_neg  = in_dec_c.is_signed && (opa_c[XLEN-1] ^ opb_c[XLEN-1]);
          ctx_d.r_neg  = in_dec_c.is_signed && opa_c[XLEN-1];
          if (div0_c || ovf_c) begin
            state_d = DONE;
            res_s_d = special_c;
          end else begin
            state_d = BUSY;
            cnt_d   = in_dec_c.is_w ? CNT_W'(MULDIV_N32) : CNT_W'(MULDIV_N64);
`ifdef MULDIV_FAST_MUL_EN
            if (in_dec_c.is_mul) cnt_d = CNT_W'(1);
`else
`endif
            mul_load_c = in_dec_c.is_mul;
            div_load_c = !in_dec_c.is_mul;
          end
        end
      end
      BUSY: begin
        cnt_d      = cnt_q - 1'b1;
        mul_step_c = ctx_q.is_mul;
        div_step_c = !ctx_q.is_mul;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          res_s_d = final_c;
        end
      end
      DONE: begin
        state_d = IDLE;
        res_d_d = res_s_q;
      end
      default: state_d = IDLE;
    endcase
    // Flush beats everything, including a start presented in IDLE.
    if (bus.flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      res_s_d    = '0;
      res_d_d    = res_d_q;
      mul_load_c = 1'b0;
      mul_step_c = 1'b0;
      div_load_c = 1'b0;
      div_step_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ctx_q    <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      res_s_q  <= '0;
      res_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctx_q    <= ctx_d;
      busy_q   <= (state_d != IDLE);
      finish_q <= (state_d == DONE);
      res_s_q  <= res_s_d;
      res_d_q  <= res_d_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (mul_load_c) begin
      mcand_q  <= opa_c;
      mplier_q <= opb_c;
    end else if (mul_step_c) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  assign mul_c = mcand_q * mplier_q;
`else
  logic [XLEN-1:0] acc_q;

  // Shift-add: the low XLEN bits are identical for signed and unsigned operands.
  assign mul_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
    end else if (mul_load_c) begin
      acc_q <= '0;
    end else if (mul_step_c) begin
      acc_q <= mul_c;
    end
  end
`endif

  div_core u_div_core (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (div_load_c),
    .step_i      (div_step_c),
    .dividend_i  (dividend_c),
    .divisor_i   (abs_b_c),
    .quo_nxt_c_o (quo_nxt_c),
    .rem_nxt_c_o (rem_nxt_c)
  );

  assign bus.busy     = busy_q;
  assign bus.finish   = finish_q;
  assign bus.result_s = res_s_q;
  assign bus.result_d = res_d_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, flush/reset aborts, then random ops vs an arithmetic model.
module tb_muldiv_unit;
  import common::*;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] last_exp;
  logic        seen;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M semantics from plain language arithmetic.
  function automatic logic [63:0] model(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] ua, ub, r32;
    logic ovf64, ovf32;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    ovf64 = (a == 64'h8000000000000000) && (b == 64'hFFFFFFFFFFFFFFFF);
    ovf32 = (ua == 32'h80000000) && (ub == 32'hFFFFFFFF);
    case (op)
      MUL:  return a * b;
      MULW: begin r32 = ua * ub; return sx(r32); end
      DIV:  begin if (b == 0) return '1; if (ovf64) return a; return sa / sb; end
      DIVU: begin if (b == 0) return '1; return a / b; end
      REM:  begin if (b == 0) return a; if (ovf64) return '0; return sa % sb; end
      REMU: begin if (b == 0) return a; return a % b; end
      DIVW: begin if (ub == 0) return '1; if (ovf32) return sx(ua); r32 = wa / wb; return sx(r32); end
      DIVUW: begin if (ub == 0) return '1; r32 = ua / ub; return sx(r32); end
      REMW: begin if (ub == 0) return sx(ua); if (ovf32) return '0; r32 = wa % wb; return sx(r32); end
      REMUW: begin if (ub == 0) return sx(ua); r32 = ua % ub; return sx(r32); end
      default: return '0;
    endcase
  endfunction

  // Cycle (counting from the accept edge) in which finish is expected.
  function automatic int exp_lat(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b);
    logic w, sgn, mul, special;
    w   = op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    sgn = op inside {DIV, REM, DIVW, REMW};
    mul = op inside {MUL, MULW};
    if (mul) begin
`ifdef MULDIV_FAST_MUL_EN
      return 2;
`else
      return w ? 33 : 65;
`endif
    end
    if (w) special = (b[31:0] == 0) || (sgn && a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF);
    else   special = (b == 0) || (sgn && a == 64'h8000000000000000 && b == 64'hFFFFFFFFFFFFFFFF);
    return special ? 1 : (w ? 33 : 65);
  endfunction

  // Called at a falling edge; the request is sampled on the next rising edge (edge 0).
  task automatic run_op(input string tag, input muldiv_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    int   lat, cyc;
    logic got;
    lat = exp_lat(op, a, b);
    bus.start = 1'b1; bus.op = op; bus.src1 = a; bus.src2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, "_busy_c1"}, bus.busy, 1'b1);
      if (bus.finish === 1'b1) got = 1'b1;
      else if (cyc == 1) chk({tag, "_rs_idle"}, bus.result_s, '0);
    end
    chk({tag, "_finish"}, got, 1'b1);
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_result_s"}, bus.result_s, exp);
    @(negedge clk);
    chk({tag, "_result_d"}, bus.result_d, exp);
    chk({tag, "_busy_after"}, bus.busy, 1'b0);
    chk({tag, "_finish_after"}, bus.finish, 1'b0);
    last_exp = exp;
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = MUL; bus.src1 = '0; bus.src2 = '0;
    resetn = 1'b1; last_exp = '0;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_finish", bus.finish, 1'b0);
    chk("rst_result_s", bus.result_s, '0);
    chk("rst_result_d", bus.result_d, '0);
    resetn = 1'b1;
    @(negedge clk);

    run_op("mul", MUL, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB);
    run_op("divw", DIVW, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD);
    run_op("remw", REMW, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF);
    run_op("divu0", DIVU, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF);
    run_op("remu0", REMU, 64'd5, 64'd0, 64'd5);
    run_op("div_ovf", DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000);
    run_op("rem_ovf", REM, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'd0);
    run_op("mulw", MULW, 64'h1234567880000001, 64'hABCD000000000003, 64'hFFFFFFFF80000003);

    // Flush during cycle 20 of a DIV, then a new start in cycle 21.
    bus.start = 1'b1; bus.op = DIV; bus.src1 = 64'd1000; bus.src2 = 64'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    chk("flush_busy_c20", bus.busy, 1'b1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_c21", bus.busy, 1'b0);
    chk("flush_finish_c21", bus.finish, 1'b0);
    chk("flush_result_d", bus.result_d, last_exp);
    run_op("after_flush", DIVU, 64'd100, 64'd7, 64'd14);

    // Flush together with start in IDLE drops the request.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = DIVU; bus.src1 = 64'd10; bus.src2 = 64'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (bus.busy === 1'b1 || bus.finish === 1'b1) seen = 1'b1;
    end
    chk("flush_start_dropped", seen, 1'b0);
    chk("flush_start_result_d", bus.result_d, last_exp);

    // Reset pulsed in cycle 10 of a MUL.
    bus.start = 1'b1; bus.op = MUL; bus.src1 = 64'd123; bus.src2 = 64'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_finish", bus.finish, 1'b0);
    chk("midrst_result_s", bus.result_s, '0);
    chk("midrst_result_d", bus.result_d, '0);
    @(negedge clk);
    resetn = 1'b1;
    last_exp = '0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.finish === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_finish", seen, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      muldiv_op_t  rop;
      logic [63:0] ra, rb;
      int          sel;
      rop = muldiv_op_t'(4'($urandom_range(0, 9)));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      sel = $urandom_range(0, 4);
      case (sel)
        1: begin
          ra = ($urandom_range(0, 1) == 1) ? -64'($urandom_range(0, 1000)) : 64'($urandom_range(0, 1000));
          rb = ($urandom_range(0, 1) == 1) ? -64'($urandom_range(1, 30)) : 64'($urandom_range(1, 30));
        end
        2: rb = ($urandom_range(0, 1) == 1) ? 64'd0 : {rb[63:32], 32'd0};
        3: begin
          ra = ($urandom_range(0, 1) == 1) ? 64'h8000000000000000 : {ra[63:32], 32'h80000000};
          rb = ($urandom_range(0, 1) == 1) ? 64'hFFFFFFFFFFFFFFFF : {rb[63:32], 32'hFFFFFFFF};
        end
        default: ;
      endcase
      run_op("rand", rop, ra, rb, model(rop, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
